// File: rtl/pdm_frame_scheduler.sv
// pdm_frame_scheduler: ping-pong buffers CIC samples and streams each full bank as a byte-serial frame (seq header + samples).
module pdm_frame_scheduler #(
    parameter int SAMPLE_W         = 24,
    parameter int FRAME_LEN        = 64,
    parameter int BYTES_PER_SAMPLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                tx_req,
    input  logic                tx_ack,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic                overflow,
    input  logic                overflow_clr,
    output logic [15:0]         overflow_cnt
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int EW = BYTES_PER_SAMPLE * 8;
    localparam int BW = BYTES_PER_SAMPLE > 2 ? $clog2(BYTES_PER_SAMPLE) : 1;

    typedef enum logic [2:0] {IDLE, REQ, HDR, PAY, DONE} state_t;

    state_t                state, nxt;
    logic [SAMPLE_W-1:0]   mem [2*FRAME_LEN];
    logic [1:0]            full;
    logic                  wr_bank, rd_bank;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [BW-1:0]         b_idx;
    logic [15:0]           seq;
    logic signed [EW-1:0]  ext;
    logic                  wr_en, drop, fire, last_byte, fill, hdr_end, smp_end;

    assign wr_en     = sample_valid && enable && !full[wr_bank];
    assign drop      = sample_valid && enable && full[wr_bank];
    assign fill      = wr_en && wr_idx == IW'(FRAME_LEN - 1);
    assign fire      = tx_valid && tx_ready;
    assign hdr_end   = b_idx == BW'(1);
    assign smp_end   = b_idx == BW'(BYTES_PER_SAMPLE - 1);
    assign last_byte = rd_idx == IW'(FRAME_LEN - 1) && smp_end;
    assign ext       = EW'($signed(mem[{rd_bank, rd_idx}]));

    assign tx_req   = state == REQ;
    assign tx_valid = state == HDR || state == PAY;
    assign tx_last  = state == PAY && last_byte;
    assign busy     = state != IDLE;
    assign tx_data  = state == HDR ? (b_idx == BW'(0) ? seq[15:8] : seq[7:0]) :
                      state == PAY ? 8'(ext >> (8 * (BYTES_PER_SAMPLE - 1 - int'(b_idx)))) : 8'h00;

    // Sample storage needs no reset: the full flags decide what is valid.
    always_ff @(posedge clk)
        if (wr_en) mem[{wr_bank, wr_idx}] <= sample_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            full         <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            b_idx        <= '0;
            seq          <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            state <= nxt;
            // Fill and release always target different banks, so both can apply at once.
            full  <= (full | (fill ? 2'b01 << wr_bank : 2'b00)) & ~(state == DONE ? 2'b01 << rd_bank : 2'b00);
            if (!enable) wr_idx <= '0;
            else if (wr_en) wr_idx <= wr_idx + IW'(1);
            if (fill) wr_bank <= ~wr_bank;
            if (state == DONE) begin
                rd_bank <= ~rd_bank;
                seq     <= seq + 16'd1;
            end
            if (fire) begin
                b_idx <= (state == HDR ? hdr_end : smp_end) ? '0 : b_idx + BW'(1);
                if (state == PAY && smp_end) rd_idx <= rd_idx + IW'(1);
            end
            if (overflow_clr) begin
                overflow     <= 1'b0;
                overflow_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = full[rd_bank] ? REQ : IDLE;
            REQ:     nxt = tx_ack ? HDR : REQ;
            HDR:     nxt = fire && hdr_end ? PAY : HDR;
            PAY:     nxt = fire && last_byte ? DONE : PAY;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pdm_frame_scheduler.sv
// tb_pdm_frame_scheduler: table-driven and randomized checks of frame scheduling against a frame-level model.
module tb_pdm_frame_scheduler;
    localparam int SW = 24, FL = 4, BPS = 3;

    logic clk = 0, rst = 1, enable = 1, sample_valid = 0, tx_ack = 0, tx_ready = 1, overflow_clr = 0;
    logic [SW-1:0] sample_data = '0;
    logic tx_req, tx_valid, tx_last, busy, overflow;
    logic [7:0] tx_data;
    logic [15:0] overflow_cnt;

    pdm_frame_scheduler #(.SAMPLE_W(SW), .FRAME_LEN(FL), .BYTES_PER_SAMPLE(BPS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_data(sample_data), .sample_valid(sample_valid),
        .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .overflow(overflow), .overflow_clr(overflow_clr),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int occ = 0, mcnt = 0, rel_pend = 0, req_cnt = 0, ack_dly = 3, rdy_mode = 0;
    logic ack_en = 1, hold_chk = 0;
    logic [8:0] held;
    logic [15:0] mseq = 0;
    logic [SW-1:0] part[$];
    logic [8:0] exp_q[$], cap[$];

    typedef struct {logic [23:0] smp; logic [23:0] bytes;} vec_t;
    vec_t tbl[FL];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: at most two frames can be waiting; a full pair drops samples.
    function automatic void m_write(logic [SW-1:0] s);
        longint v;
        if (occ == 2) begin
            if (mcnt < 65535) mcnt++;
            return;
        end
        part.push_back(s);
        if (part.size() == FL) begin
            exp_q.push_back({1'b0, mseq[15:8]});
            exp_q.push_back({1'b0, mseq[7:0]});
            for (int i = 0; i < FL; i++) begin
                v = longint'($signed(part[i]));
                for (int k = 0; k < BPS; k++)
                    exp_q.push_back({1'(i == FL - 1 && k == BPS - 1), 8'(v >> (8 * (BPS - 1 - k)))});
            end
            mseq++;
            occ++;
            part.delete();
        end
    endfunction

    task automatic wr(logic [SW-1:0] s);
        sample_data = s;
        sample_valid = 1;
        if (enable) m_write(s);
        tick;
        sample_valid = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        rst = 0;
        exp_q.delete();
        part.delete();
        cap.delete();
        occ = 0;
        mcnt = 0;
        mseq = 0;
        rel_pend = 0;
    endtask

    task automatic wait_idle(string nm);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && occ == 0 && rel_pend == 0 && !busy) break;
            tick;
        end
        chk({nm, "_drained"}, i < 3000, 1);
    endtask

    task automatic run_table(string nm, logic [15:0] hdr);
        cap.delete();
        foreach (tbl[i]) wr(tbl[i].smp);
        wait_idle(nm);
        chk({nm, "_len"}, cap.size(), 2 + FL * BPS);
        if (cap.size() == 2 + FL * BPS) begin
            chk({nm, "_hdr_hi"}, cap[0], {1'b0, hdr[15:8]});
            chk({nm, "_hdr_lo"}, cap[1], {1'b0, hdr[7:0]});
            for (int i = 0; i < FL; i++)
                for (int k = 0; k < BPS; k++)
                    chk({nm, "_byte"}, cap[2 + BPS * i + k],
                        {1'(i == FL - 1 && k == BPS - 1), 8'(tbl[i].bytes >> (8 * (BPS - 1 - k)))});
        end
        chk({nm, "_busy"}, busy, 0);
    endtask

    // Ack and ready drivers.
    initial forever begin
        tick;
        tx_ack = 0;
        tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~tx_ready : 1'($urandom_range(0, 1));
        if (ack_en && tx_req && !rst) begin
            req_cnt++;
            if (req_cnt > ack_dly) begin
                tx_ack = 1;
                req_cnt = 0;
            end
        end else req_cnt = 0;
    end

    // Byte monitor: checks hold rule and each accepted byte against the model.
    always @(negedge clk) begin
        if (rst) hold_chk = 0;
        else begin
            if (rel_pend > 0 && --rel_pend == 0) occ--;
            if (hold_chk) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", {tx_last, tx_data}, held);
            end
            hold_chk = tx_valid && !tx_ready;
            held = {tx_last, tx_data};
            if (tx_valid && tx_ready) begin
                cap.push_back({tx_last, tx_data});
                if (exp_q.size() == 0) chk("unexpected_byte", {tx_last, tx_data}, 9'h1ff & ~{tx_last, tx_data});
                else chk("stream_byte", {tx_last, tx_data}, exp_q.pop_front());
                if (tx_last) rel_pend = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{24'h000001, 24'h000001};
        tbl[1] = '{24'h7FFFFF, 24'h7FFFFF};
        tbl[2] = '{24'h800000, 24'h800000};
        tbl[3] = '{24'hFFFFFE, 24'hFFFFFE};
        tick;
        do_reset;
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_overflow_cnt", overflow_cnt, 0);

        run_table("single", 16'h0000);
        rdy_mode = 1;
        run_table("backpressure", 16'h0001);
        rdy_mode = 0;

        do_reset;
        ack_en = 0;
        for (int i = 0; i < 11; i++) wr(24'(i * 16'h1111));
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt", overflow_cnt, 3);
        chk("ovf_req", tx_req, 1);
        overflow_clr = 1;
        wr(24'h123456);
        overflow_clr = 0;
        mcnt = 0;
        chk("ovf_clr_flag", overflow, 0);
        chk("ovf_clr_cnt", overflow_cnt, 0);
        ack_en = 1;
        wait_idle("ovf");
        chk("ovf_frames", cap.size(), 2 * (2 + FL * BPS));
        if (cap.size() == 2 * (2 + FL * BPS)) begin
            chk("ovf_seq0_lo", cap[1], 9'h000);
            chk("ovf_seq1_hi", cap[14], 9'h000);
            chk("ovf_seq1_lo", cap[15], 9'h001);
        end
        chk("ovf_cnt_after", overflow_cnt, 0);

        do_reset;
        ack_dly = 0;
        for (int i = 0; i < 2 * FL; i++) wr(24'($urandom));
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (tx_valid && tx_ready && tx_last) break;
            end
            chk("done_wait", n < 200, 1);
        end
        tick;
        chk("done_state_busy", busy, 1);
        wr(24'hABCDEF);
        chk("done_drop_cnt", overflow_cnt, 1);
        for (int i = 0; i < FL; i++) wr(24'($urandom));
        wait_idle("done");
        chk("done_cnt_final", overflow_cnt, 1);
        ack_dly = 3;

        do_reset;
        force dut.seq = 16'hFFFF;
        tick;
        release dut.seq;
        mseq = 16'hFFFF;
        run_table("wrap_a", 16'hFFFF);
        run_table("wrap_b", 16'h0000);

        do_reset;
        wr(24'h111111);
        wr(24'h222222);
        enable = 0;
        part.delete();
        repeat (5) begin
            sample_valid = 1;
            sample_data = 24'($urandom);
            tick;
        end
        sample_valid = 0;
        enable = 1;
        chk("en_busy", busy, 0);
        run_table("enable", 16'h0000);
        chk("en_cnt", overflow_cnt, 0);

        do_reset;
        foreach (tbl[i]) wr(tbl[i].smp);
        begin
            int n;
            for (n = 0; n < 200 && cap.size() < 6; n++) tick;
            chk("rstpay_wait", n < 200, 1);
        end
        rst = 1;
        tick;
        chk("rstpay_valid", tx_valid, 0);
        chk("rstpay_req", tx_req, 0);
        chk("rstpay_busy", busy, 0);
        chk("rstpay_last", tx_last, 0);
        do_reset;
        run_table("after_rst", 16'h0000);

        rdy_mode = 2;
        for (int c = 0; c < 400; c++) begin
            ack_dly = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) begin
                enable = 0;
                part.delete();
                tick;
                enable = 1;
            end else if ($urandom_range(0, 2) != 0) wr(24'($urandom));
            else tick;
        end
        wait_idle("random");
        chk("random_cnt", overflow_cnt, mcnt);
        chk("random_flag", overflow, mcnt != 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
